// File: rtl/f_ifu_pkg.sv
// Shared constants and types for the fetch stage: reset PC, next-PC select
// encodings and the layout of the F/D pipeline register.
package f_ifu_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [31:0]      PC_INIT_DEFAULT = 32'h0000_3000;
  localparam logic [SEL_W-1:0] SEL_PC4         = 2'b00;
  localparam logic [SEL_W-1:0] SEL_NPC         = 2'b01;
  localparam logic [SEL_W-1:0] SEL_JR          = 2'b10;

  localparam int unsigned FD_W = 96;

  // Field order fixes the bit layout of the 96-bit F/D register.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc4;
  } fd_t;

  // Next fetch PC. The reserved select 2'b11 falls through to sequential,
  // and npc is only ever passed when the select is explicitly SEL_NPC.
  function automatic logic [31:0] next_pc(input logic [SEL_W-1:0] sel,
                                          input logic [31:0]      pc4,
                                          input logic [31:0]      npc,
                                          input logic [31:0]      jr_target);
    logic [31:0] res;
    res = pc4;
    if (sel == SEL_NPC) begin
      res = npc;
    end else if (sel == SEL_JR) begin
      res = jr_target;
    end
    return res;
  endfunction

endpackage

// File: rtl/f_ifu_fd_reg.sv
// F/D pipeline register: a plain 96-bit register with synchronous reset
// to zero (sll nop, zero PCs) and a load enable that the hazard unit
// deasserts while stalling.
module fd_reg
  import f_ifu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [FD_W-1:0] fd_d,
  output logic [FD_W-1:0] fd_q
);

  logic [FD_W-1:0] fd_q_r;

  // Reset beats enable; a disabled register simply holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      fd_q_r <= '0;
    end else if (en) begin
      fd_q_r <= fd_d;
    end
  end

  assign fd_q = fd_q_r;

endmodule

// File: rtl/f_ifu.sv
// Fetch-stage instruction fetch unit: fetch PC register, next-PC mux and
// the F/D register feeding decode. Single delay slot, so a redirect never
// squashes the instruction fetched alongside it.
module f_ifu
  import f_ifu_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [SEL_W-1:0] pc_sel_D,
  input  logic [31:0]      npc_D,
  input  logic [31:0]      jr_target_D,
  input  logic [31:0]      instr_F,
  output logic [31:0]      pc_F,
  output logic [31:0]      pc_D,
  output logic [31:0]      pc4_D,
  output logic [31:0]      ir_D
);

  logic [31:0]     pc_q;
  logic [31:0]     pc_d;
  logic [31:0]     pc4_F;
  fd_t             fd_in;
  logic [FD_W-1:0] fd_raw;
  fd_t             fd_out;

  assign pc4_F = pc_q + 32'd4;

  // Next-PC selection; stall handling lives in the register so a held
  // branch re-presents its select once the stall drops.
  always_comb begin
    pc_d = next_pc(pc_sel_D, pc4_F, npc_D, jr_target_D);
  end

  // Fetch PC register: reset has priority, stall freezes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_INIT;
    end else if (!stall) begin
      pc_q <= pc_d;
    end
  end

  // Pack the fetched instruction and its PCs for the F/D register.
  always_comb begin
    fd_in     = '0;
    fd_in.ir  = instr_F;
    fd_in.pc  = pc_q;
    fd_in.pc4 = pc4_F;
  end

  fd_reg u_fd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .fd_d  (fd_in),
    .fd_q  (fd_raw)
  );

  assign fd_out = fd_t'(fd_raw);
  assign pc_F   = pc_q;
  assign pc_D   = fd_out.pc;
  assign pc4_D  = fd_out.pc4;
  assign ir_D   = fd_out.ir;

endmodule

// File: tb/tb_f_ifu.sv
// Bench for f_ifu: a directed vector table walking reset, sequential fetch,
// branch with delay slot, jr, stall-with-redirect, wrap and mid-run reset,
// followed by randomized traffic against a cycle-level reference model.
module tb_f_ifu;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel_D;
  logic [31:0] npc_D;
  logic [31:0] jr_target_D;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] pc_D;
  logic [31:0] pc4_D;
  logic [31:0] ir_D;

  int checks = 0;
  int errors = 0;
  logic im_mode = 1'b0;

  f_ifu dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_sel_D    (pc_sel_D),
    .npc_D       (npc_D),
    .jr_target_D (jr_target_D),
    .instr_F     (instr_F),
    .pc_F        (pc_F),
    .pc_D        (pc_D),
    .pc4_D       (pc4_D),
    .ir_D        (ir_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = address in directed mode, scrambled otherwise.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  always_comb instr_F = im_mode ? im_word(pc_F) : pc_F;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  sel;
    logic [31:0] npc;
    logic [31:0] jr;
    logic [31:0] e_pc_F;
    logic [31:0] e_pc_D;
    logic [31:0] e_ir_D;
    logic [31:0] e_pc4_D;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [1:0] sel, logic [31:0] npc,
                              logic [31:0] jr, logic [31:0] epf, logic [31:0] epd,
                              logic [31:0] eir, logic [31:0] ep4);
    vec_t v;
    v.rst = r; v.stl = s; v.sel = sel; v.npc = npc; v.jr = jr;
    v.e_pc_F = epf; v.e_pc_D = epd; v.e_ir_D = eir; v.e_pc4_D = ep4;
    return v;
  endfunction

  // Reference model state for the random phase.
  logic [31:0] m_pc, m_pc_D, m_ir_D, m_pc4_D;

  initial begin
    reset = 1'b1; stall = 1'b1; pc_sel_D = 2'b01; npc_D = 32'h3040; jr_target_D = '0;

    //            rst stl sel    npc           jr            pc_F          pc_D          ir_D          pc4_D
    vecs.push_back(mk(1, 1, 2'b01, 32'h3040,     32'h0,        32'h3000,     32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 2'b01, 32'h3040,     32'h0,        32'h3000,     32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3004,     32'h3000,     32'h3000,     32'h3004));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3008,     32'h3004,     32'h3004,     32'h3008));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h300C,     32'h3008,     32'h3008,     32'h300C));
    vecs.push_back(mk(0, 0, 2'b01, 32'h3020,     32'h0,        32'h3020,     32'h300C,     32'h300C,     32'h3010));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3024,     32'h3020,     32'h3020,     32'h3024));
    vecs.push_back(mk(0, 0, 2'b10, 32'hDEAD0000, 32'h3100,     32'h3100,     32'h3024,     32'h3024,     32'h3028));
    vecs.push_back(mk(0, 0, 2'b11, 32'hDEAD0000, 32'hBEEF0000, 32'h3104,     32'h3100,     32'h3100,     32'h3104));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0,        32'h3010,     32'h3010,     32'h3104,     32'h3104,     32'h3108));
    vecs.push_back(mk(0, 1, 2'b01, 32'h3040,     32'h0,        32'h3010,     32'h3104,     32'h3104,     32'h3108));
    vecs.push_back(mk(0, 1, 2'b01, 32'h3040,     32'h0,        32'h3010,     32'h3104,     32'h3104,     32'h3108));
    vecs.push_back(mk(0, 1, 2'b01, 32'h3040,     32'h0,        32'h3010,     32'h3104,     32'h3104,     32'h3108));
    vecs.push_back(mk(0, 0, 2'b01, 32'h3040,     32'h0,        32'h3040,     32'h3010,     32'h3010,     32'h3014));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3044,     32'h3040,     32'h3040,     32'h3044));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h3044,     32'h3044,     32'h3048));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 32'h3020,     32'h0,        32'h3000,     32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3004,     32'h3000,     32'h3000,     32'h3004));
    vecs.push_back(mk(0, 0, 2'b10, 32'h0,        32'h3102,     32'h3102,     32'h3004,     32'h3004,     32'h3008));
    vecs.push_back(mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h3106,     32'h3102,     32'h3102,     32'h3106));

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl; pc_sel_D = vecs[i].sel;
      npc_D = vecs[i].npc; jr_target_D = vecs[i].jr;
      @(posedge clk); #1;
      chk($sformatf("v%0d pc_F", i),  pc_F,  vecs[i].e_pc_F);
      chk($sformatf("v%0d pc_D", i),  pc_D,  vecs[i].e_pc_D);
      chk($sformatf("v%0d ir_D", i),  ir_D,  vecs[i].e_ir_D);
      chk($sformatf("v%0d pc4_D", i), pc4_D, vecs[i].e_pc4_D);
    end

    // Random phase: scrambled IM contents, model starts from a reset.
    im_mode = 1'b1;
    m_pc = 32'h3000; m_pc_D = '0; m_ir_D = '0; m_pc4_D = '0;
    reset = 1'b1; stall = 1'b0; pc_sel_D = 2'b00;
    @(posedge clk); #1;
    chk("rnd reset pc_F", pc_F, m_pc);

    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 31) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      pc_sel_D    = 2'($urandom_range(0, 3));
      npc_D       = {$urandom()} & 32'hFFFF_FFFC;
      jr_target_D = $urandom();
      if (reset) begin
        m_pc = 32'h3000; m_pc_D = '0; m_ir_D = '0; m_pc4_D = '0;
      end else if (!stall) begin
        m_ir_D  = im_word(m_pc);
        m_pc_D  = m_pc;
        m_pc4_D = m_pc + 32'd4;
        case (pc_sel_D)
          2'b01:   m_pc = npc_D;
          2'b10:   m_pc = jr_target_D;
          default: m_pc = m_pc + 32'd4;
        endcase
      end
      @(posedge clk); #1;
      chk($sformatf("r%0d pc_F", n),  pc_F,  m_pc);
      chk($sformatf("r%0d pc_D", n),  pc_D,  m_pc_D);
      chk($sformatf("r%0d ir_D", n),  ir_D,  m_ir_D);
      chk($sformatf("r%0d pc4_D", n), pc4_D, m_pc4_D);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
